// File: rtl/anneal_scheduler_if.sv
// anneal_scheduler_if: host config/status and PE-array control bundle for the annealing scheduler
interface anneal_scheduler_if #(
    parameter int NUM_SPINS = 16,
    parameter int H_WIDTH   = 32,
    parameter int ITER_W    = 16
);
    logic                 start;
    logic                 abort;
    logic [ITER_W-1:0]    iter_limit;
    logic [7:0]           settle_cycles;
    logic [7:0]           temp_step;
    logic [3:0]           noise_init;
    logic [H_WIDTH-1:0]   hamiltonian;
    logic                 pe_reset;
    logic                 pe_ena;
    logic [NUM_SPINS-1:0] random_mask;
    logic                 busy;
    logic                 done;
    logic [ITER_W-1:0]    iter_count;
    logic [H_WIDTH-1:0]   best_h;
    logic [ITER_W-1:0]    best_iter;
    logic [3:0]           noise_level;

    modport master (
        output start, abort, iter_limit, settle_cycles, temp_step, noise_init, hamiltonian,
        input  pe_reset, pe_ena, random_mask, busy, done, iter_count, best_h, best_iter, noise_level
    );

    modport slave (
        input  start, abort, iter_limit, settle_cycles, temp_step, noise_init, hamiltonian,
        output pe_reset, pe_ena, random_mask, busy, done, iter_count, best_h, best_iter, noise_level
    );
endinterface

// File: rtl/anneal_scheduler.sv
// anneal_scheduler: runs the PE array through annealing iterations, tracking the minimum Hamiltonian
module anneal_scheduler #(
    parameter int          NUM_SPINS = 16,
    parameter int          H_WIDTH   = 32,
    parameter int          ITER_W    = 16,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2024
) (
    input logic               clk,
    input logic               reset_n,
    anneal_scheduler_if.slave bus
);
    typedef enum logic [2:0] {IDLE, INIT0, INIT1, RUN, SAMPLE, NEXT, DONE} state_t;
    state_t state, state_nxt;
    logic [ITER_W-1:0]    lim, iter_cnt, best_iter, iter_inc;
    logic [7:0]           settle, tstep, cnt, tcnt, tcnt_inc;
    logic [3:0]           noise, noise_nxt;
    logic [31:0]          lfsr, lfsr_nxt;
    logic [H_WIDTH-1:0]   best_h;
    logic [NUM_SPINS-1:0] mask;
    logic                 start_ok, last_iter, tick;

    assign start_ok  = bus.start && (state == IDLE || state == DONE);
    assign iter_inc  = iter_cnt + 1'b1;
    assign last_iter = iter_inc == lim;
    // Galois form of x^32 + x^22 + x^2 + x + 1
    assign lfsr_nxt  = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0);
    assign tcnt_inc  = tcnt + 8'd1;
    assign tick      = tstep != 8'd0 && tcnt_inc == tstep;
    assign noise_nxt = tick && noise != 4'd0 ? noise - 4'd1 : noise;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = bus.abort ? IDLE :
                    (state == IDLE || state == DONE) ? (bus.start ? INIT0 : state) :
                    state == INIT0 ? INIT1 :
                    state == INIT1 ? RUN :
                    state == RUN ? (cnt == 8'd1 ? SAMPLE : RUN) :
                    state == SAMPLE ? NEXT :
                    last_iter ? DONE : RUN;
    end

    always_comb begin
        bus.pe_reset = state == IDLE || state == INIT0 || state == INIT1;
        bus.pe_ena   = state == RUN;
        bus.busy     = !(state == IDLE || state == DONE);
        bus.done     = state == DONE;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            lim       <= '0;
            settle    <= '0;
            tstep     <= '0;
            cnt       <= '0;
            tcnt      <= '0;
            iter_cnt  <= '0;
            best_h    <= '1;
            best_iter <= '0;
            noise     <= '0;
            lfsr      <= LFSR_SEED;
            mask      <= '0;
        end else if (bus.abort) begin
            mask <= '0;
        end else begin
            if (start_ok) begin
                lim       <= bus.iter_limit == '0 ? ITER_W'(1) : bus.iter_limit;
                settle    <= bus.settle_cycles == 8'd0 ? 8'd1 : bus.settle_cycles;
                tstep     <= bus.temp_step;
                iter_cnt  <= '0;
                best_h    <= '1;
                best_iter <= '0;
                noise     <= bus.noise_init;
                tcnt      <= '0;
                mask      <= '0;
            end
            if (state == INIT1 || (state == NEXT && !last_iter)) cnt <= settle;
            else if (state == RUN) cnt <= cnt - 8'd1;
            if (state == SAMPLE && bus.hamiltonian < best_h) begin
                best_h    <= bus.hamiltonian;
                best_iter <= iter_cnt;
            end
            if (state == NEXT) begin
                iter_cnt <= iter_inc;
                lfsr     <= lfsr_nxt;
                tcnt     <= tick ? 8'd0 : tcnt_inc;
                noise    <= noise_nxt;
                mask     <= noise_nxt > lfsr_nxt[31:28] ? lfsr_nxt[NUM_SPINS-1:0] : '0;
            end
        end

    assign bus.random_mask = mask;
    assign bus.iter_count  = iter_cnt;
    assign bus.best_h      = best_h;
    assign bus.best_iter   = best_iter;
    assign bus.noise_level = noise;
endmodule

// File: tb/tb_anneal_scheduler.sv
// tb_anneal_scheduler: randomized bench with a phase-arithmetic reference model of the scheduler
module tb_anneal_scheduler;
    localparam int P_INIT = 0, P_RUN = 1, P_SAMPLE = 2, P_NEXT = 3;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    anneal_scheduler_if bus ();
    anneal_scheduler dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int tests = 0, fails = 0;
    bit mon_en = 1'b0, use_tab = 1'b0;
    logic [31:0] htab [4] = '{32'd50, 32'd20, 32'd20, 32'd35};

    // model: run position is a cycle offset since start; phase comes from arithmetic on it
    bit          m_run, m_done;
    int          m_k, m_lim, m_s, m_ts, m_ninit, m_iters, m_bi;
    logic [31:0] m_best, m_lfsr;
    logic [15:0] m_mask;

    function automatic int phase(int k, int s);
        int r;
        if (k < 2) return P_INIT;
        r = (k - 2) % (s + 2);
        return r < s ? P_RUN : (r == s ? P_SAMPLE : P_NEXT);
    endfunction

    function automatic int m_noise();
        if (m_ts == 0) return m_ninit;
        return m_ninit > m_iters / m_ts ? m_ninit - m_iters / m_ts : 0;
    endfunction

    function automatic logic [31:0] lstep(logic [31:0] x);
        return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        int p, j;
        if (!reset_n) begin
            m_run = 0; m_done = 0; m_k = 0; m_lim = 1; m_s = 1; m_ts = 0; m_ninit = 0;
            m_iters = 0; m_best = '1; m_bi = 0; m_lfsr = 32'hACE1_2024; m_mask = '0;
        end else if (bus.abort) begin
            m_run = 0; m_done = 0; m_mask = '0;
        end else if (!m_run) begin
            if (bus.start) begin
                m_lim = bus.iter_limit == 0 ? 1 : int'(bus.iter_limit);
                m_s = bus.settle_cycles == 0 ? 1 : int'(bus.settle_cycles);
                m_ts = int'(bus.temp_step);
                m_ninit = int'(bus.noise_init);
                m_k = 0; m_run = 1; m_done = 0; m_iters = 0; m_best = '1; m_bi = 0; m_mask = '0;
            end
        end else begin
            p = phase(m_k, m_s);
            j = m_k < 2 ? 0 : (m_k - 2) / (m_s + 2);
            if (p == P_SAMPLE && bus.hamiltonian < m_best) begin
                m_best = bus.hamiltonian;
                m_bi = j;
            end
            if (p == P_NEXT) begin
                m_iters = j + 1;
                m_lfsr = lstep(m_lfsr);
                m_mask = m_noise() > int'(m_lfsr[31:28]) ? m_lfsr[15:0] : 16'h0;
            end
            m_k++;
            if (m_k == 2 + m_lim * (m_s + 2)) begin
                m_run = 0;
                m_done = 1;
            end
        end
    end

    always @(negedge clk)
        if (use_tab) bus.hamiltonian = m_iters < 4 ? htab[m_iters] : 32'h0;
        else bus.hamiltonian = $urandom_range(0, 7) == 0 ? $urandom() : 32'($urandom_range(0, 63));

    always @(negedge clk)
        if (mon_en && reset_n) begin
            chk("pe_reset", 64'(bus.pe_reset), 64'(m_run ? m_k < 2 : !m_done));
            chk("pe_ena", 64'(bus.pe_ena), 64'(m_run && phase(m_k, m_s) == P_RUN));
            chk("busy", 64'(bus.busy), 64'(m_run));
            chk("done", 64'(bus.done), 64'(m_done));
            chk("random_mask", 64'(bus.random_mask), 64'(m_mask));
            chk("iter_count", 64'(bus.iter_count), 64'(m_iters));
            chk("best_h", 64'(bus.best_h), 64'(m_best));
            chk("best_iter", 64'(bus.best_iter), 64'(m_bi));
            chk("noise_level", 64'(bus.noise_level), 64'(m_noise()));
        end

    task automatic pulse_start(int lim, int s, int ts, int ni);
        bus.iter_limit = 16'(lim);
        bus.settle_cycles = 8'(s);
        bus.temp_step = 8'(ts);
        bus.noise_init = 4'(ni);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic run_until_done(string nm, output int n, output int ena);
        n = 0;
        ena = 0;
        while (n < 1000) begin
            @(negedge clk);
            n++;
            if (bus.pe_ena) ena++;
            if (bus.done) return;
        end
        tests++;
        fails++;
        $display("FAIL %s: done not seen after %0d cycles", nm, n);
    endtask

    task automatic wait_ena_iter(string nm, int it);
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (bus.pe_ena && bus.iter_count == 16'(it)) return;
        end
        tests++;
        fails++;
        $display("FAIL %s: RUN of iteration %0d not seen", nm, it);
    endtask

    task automatic wait_not_busy(string nm, bit stray);
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (!bus.busy) begin
                bus.start = 1'b0;
                return;
            end
            bus.start = stray && $urandom_range(0, 7) == 0;
        end
        bus.start = 1'b0;
        tests++;
        fails++;
        $display("FAIL %s: busy still high", nm);
    endtask

    initial begin
        int n, ena;
        reset_n = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.iter_limit = '0;
        bus.settle_cycles = '0;
        bus.temp_step = '0;
        bus.noise_init = '0;
        repeat (3) @(negedge clk);
        chk("rst_pe_reset", 64'(bus.pe_reset), 64'd1);
        chk("rst_pe_ena", 64'(bus.pe_ena), 64'd0);
        chk("rst_mask", 64'(bus.random_mask), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_best_h", 64'(bus.best_h), 64'hFFFF_FFFF);
        chk("rst_noise", 64'(bus.noise_level), 64'd0);
        reset_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        pulse_start(3, 4, 0, 0);
        run_until_done("t1", n, ena);
        chk("t1_latency", 64'(n), 64'd20);
        chk("t1_ena_cycles", 64'(ena), 64'd12);
        chk("t1_iter_count", 64'(bus.iter_count), 64'd3);

        use_tab = 1'b1;
        pulse_start(4, 3, 0, 0);
        run_until_done("t2", n, ena);
        use_tab = 1'b0;
        chk("t2_best_h", 64'(bus.best_h), 64'd20);
        chk("t2_best_iter", 64'(bus.best_iter), 64'd1);
        chk("t2_iter_count", 64'(bus.iter_count), 64'd4);

        pulse_start(8, 2, 2, 3);
        wait_ena_iter("t3_mid", 2);
        chk("t3_noise_after2", 64'(bus.noise_level), 64'd2);
        run_until_done("t3", n, ena);
        chk("t3_noise_final", 64'(bus.noise_level), 64'd0);
        chk("t3_mask_final", 64'(bus.random_mask), 64'd0);

        pulse_start(5, 3, 0, 15);
        wait_ena_iter("t4", 1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("t4_pe_ena", 64'(bus.pe_ena), 64'd0);
        chk("t4_pe_reset", 64'(bus.pe_reset), 64'd1);
        chk("t4_mask", 64'(bus.random_mask), 64'd0);
        chk("t4_busy", 64'(bus.busy), 64'd0);
        chk("t4_iter_kept", 64'(bus.iter_count), 64'd1);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("t4_abort_wins", 64'(bus.busy), 64'd0);

        pulse_start(0, 0, 1, 4);
        run_until_done("t5", n, ena);
        chk("t5_latency", 64'(n), 64'd5);
        chk("t5_ena_cycles", 64'(ena), 64'd1);
        chk("t5_iter_count", 64'(bus.iter_count), 64'd1);

        pulse_start(3, 4, 0, 7);
        wait_ena_iter("t6", 0);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_pe_ena", 64'(bus.pe_ena), 64'd0);
        chk("t6_pe_reset", 64'(bus.pe_reset), 64'd1);
        chk("t6_busy", 64'(bus.busy), 64'd0);
        chk("t6_best_h", 64'(bus.best_h), 64'hFFFF_FFFF);
        chk("t6_noise", 64'(bus.noise_level), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        pulse_start(2, 2, 1, 2);
        run_until_done("t6_rerun", n, ena);
        chk("t6_rerun_latency", 64'(n), 64'd10);
        chk("t6_rerun_iter", 64'(bus.iter_count), 64'd2);

        for (int r = 0; r < 40; r++) begin
            pulse_start($urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 15));
            bus.iter_limit = 16'($urandom_range(0, 9));
            bus.settle_cycles = 8'($urandom_range(0, 9));
            bus.temp_step = 8'($urandom_range(0, 9));
            bus.noise_init = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 30)) @(negedge clk);
                bus.abort = 1'b1;
                @(negedge clk);
                bus.abort = 1'b0;
            end
            wait_not_busy("rand_run", 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
